eth_cfg_ram: RTL and testbench
==============================

# eth_cfg_ram

Parametrised Ethernet configuration register bank sitting on the rx pipe and tx ring, generalising the single MAC-address store to `CFG_WORDS` 32-bit words. It captures a configuration write packet addressed to its PID, validates length and error status, and updates the register bank atomically. It filters duplicate retransmissions by sequence number. Every accepted or rejected write is answered on the tx ring with an ack or nack carrying a read-back of the full bank.

## Interface
- `CFG_WORDS`, 2: number of 32-bit config words, range 1..15.
- `PID`, `MACPID`: packet id this unit responds to.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `cfg_data`  out  32*CFG_WORDS  config bank. Word 0 is bits [31:0] and is the first data word received.
- `cfg_valid`  out  1  set by the first successful write; cleared only by reset.
- `cfg_update`  out  1  one-cycle pulse in the cycle `cfg_data` changes.
- `rx_pipe_in`  in  eth_rx_pipe_data_type  rx pipe input.
- `rx_pipe_out`  out  eth_rx_pipe_data_type  rx pipe input registered, passed through unmodified.
- `tx_ring_in`  in  eth_tx_ring_data_type  tx ring input.
- `tx_ring_out`  out  eth_tx_ring_data_type  tx ring input registered, with overrides while replying.

## Operation
- **States:** IDLE, RECV, WAIT_TOKEN, WAIT_APPEND, SEND.
- **IDLE:**
  - Leave on `rx_start` only when `header.pid==PID` and `ptype==rstPacketType`.
  - On leaving: latch `header.seqnum` raw, clear the word counter and the shadow buffer, go to RECV.
- **RECV, `rx_data`:**
  - Write `msg.data` into shadow[count].
  - Counter saturates at `CFG_WORDS+1`; writes beyond `CFG_WORDS` are discarded.
- **RECV, `rx_start`:** discard the frame in progress and restart capture, applying the IDLE acceptance test.
- **RECV, `rx_end`:**
  - `ok = (count==CFG_WORDS) && !msg.data[0]`.
  - `dup = ok && cfg_valid && seqnum==last_seqnum`.
  - If `ok && !dup`: copy shadow to `cfg_data`, set `cfg_valid`, pulse `cfg_update`, `last_seqnum<=seqnum`.
  - Reply type is `ackPacketType` if `ok`, else `nackPacketType`.
  - Go to WAIT_TOKEN.
- **WAIT_TOKEN:**
  - On `tx_start_empty`: drive `stype=tx_start`, `header.pid=PID`, `header.seqnum=ldsts_big_endian(seqnum)`, `header.ptype`=reply type, then go to SEND.
  - On `tx_start`: go to WAIT_APPEND.
  - Any other stype passes through.
- **WAIT_APPEND:** on the first `tx_none`, drive `slot_start` with the same header and go to SEND.
- **SEND:**
  - `CFG_WORDS` cycles of `slot_data`, `msg.data=cfg_data` word i, i=0..N-1. On nack this is the unchanged bank.
  - Then one trailer `slot_data` with `msg.data={ldsts_big_endian(seqnum), PID, reply type}`.
  - Then return to IDLE.
- **Packets during reply:** all rx packets arriving in WAIT_TOKEN, WAIT_APPEND or SEND are ignored (one outstanding reply). They still pass through `rx_pipe_out`.
- **Pass-through:** the rx pipe is never modified. The tx ring passes through except in the override cycles above.

## Timing
- **Reset values:** `cfg_data=0`, `cfg_valid=0`, `cfg_update=0`, `last_seqnum=0`, state IDLE, `rx_pipe_out.stype=rx_none`, `tx_ring_out.stype=tx_none`.
- **Reset behaviour:** all of the above take effect asynchronously on reset assertion. Reset mid-reply truncates the reply with no trailer; reset mid-frame discards the shadow.
- **Latency:** `rx_pipe_out` and `tx_ring_out` are exactly 1 cycle after their inputs.
- **Bank update:** `cfg_data` and `cfg_update` change in the cycle after `rx_end` is sampled.
- **Reply start:** earliest header is 1 cycle after the WAIT_TOKEN entry cycle, i.e. the token seen in the cycle after `rx_end`.
- **Reply body:** data words follow the header on consecutive cycles with no gaps. Reply length is `CFG_WORDS+2` ring cycles including the header.
- **`rx_end` with count 0:** nack.
- **`rx_end` in IDLE:** ignored.

## Test plan
- **Good write:** CFG_WORDS=2, PID=MACPID, seq 0x0102, data 0x00112233, 0x44550000, end data[0]=0, empty token.
  - `cfg_data={0x44550000,0x00112233}`, `cfg_update` 1 cycle, `cfg_valid=1`.
  - tx: tx_start header ack, seq 0x0201, then 0x00112233, 0x44550000, trailer.
- **Short frame and error bit:**
  - Frame with 1 word: nack, bank unchanged, no `cfg_update`.
  - 2-word frame with end data[0]=1: nack, bank unchanged, no `cfg_update`.
  - A 3-word frame: nack, bank unchanged.
- **Duplicate:** repeat the good write with the same seq but new data: ack, bank keeps the old value, no `cfg_update`. The same data with seq+1 updates the bank.
- **Occupied token:** `tx_start` token, then 2 other cycles, then `tx_none`: slot_start header emitted in the `tx_none` output cycle, followed by 3 contiguous `slot_data`.
- **Reset and filtering:**
  - Assert reset mid-SEND between edges: `tx_ring_out.stype` goes to `tx_none` immediately and all outputs reach reset values.
  - A wrong-PID packet afterwards is passed through only.
  - CFG_WORDS=4 good write gives a 6-cycle reply.

Source files
------------

// File: rtl/eth_cfg_ram_if.sv
// Packet types shared by the rx pipe and tx ring, plus the config-bank bus interface.
// Interface is a plain wire bundle: no latency, no backpressure (ring/pipe slots are never stalled).
package eth_pkg;
  typedef enum logic [1:0] {rx_none = 2'd0, rx_start, rx_data, rx_end} eth_rx_stype_t;
  typedef enum logic [2:0] {tx_none = 3'd0, tx_start, tx_start_empty, tx_data, slot_start, slot_data} eth_tx_stype_t;

  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  ptype;
    logic [15:0] seqnum;
  } eth_header_t;

  typedef union packed {
    eth_header_t header;
    logic [31:0] data;
  } eth_msg_t;

  typedef struct packed {
    eth_rx_stype_t stype;
    eth_msg_t      msg;
  } eth_rx_pipe_data_type;

  typedef struct packed {
    eth_tx_stype_t stype;
    eth_msg_t      msg;
  } eth_tx_ring_data_type;

  localparam logic [7:0] MACPID         = 8'h05;
  localparam logic [7:0] rstPacketType  = 8'h21;
  localparam logic [7:0] ackPacketType  = 8'h22;
  localparam logic [7:0] nackPacketType = 8'h23;

  function automatic logic [15:0] ldsts_big_endian(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction
endpackage

interface eth_cfg_ram_if #(parameter int CFG_WORDS = 2);
  import eth_pkg::*;

  logic [32*CFG_WORDS-1:0] cfg_data;
  logic                    cfg_valid;
  logic                    cfg_update;
  eth_rx_pipe_data_type    rx_pipe_in;
  eth_rx_pipe_data_type    rx_pipe_out;
  eth_tx_ring_data_type    tx_ring_in;
  eth_tx_ring_data_type    tx_ring_out;

  modport master (
    output rx_pipe_in, tx_ring_in,
    input  rx_pipe_out, tx_ring_out, cfg_data, cfg_valid, cfg_update
  );

  modport slave (
    input  rx_pipe_in, tx_ring_in,
    output rx_pipe_out, tx_ring_out, cfg_data, cfg_valid, cfg_update
  );
endinterface

// File: rtl/eth_cfg_ram.sv
// Config register bank written by rx packets, answered with ack/nack + bank read-back on the tx ring.
// Pipe and ring are registered with 1-cycle latency; no backpressure, reply waits for a free ring token.
module eth_cfg_ram
  import eth_pkg::*;
#(
  parameter int         CFG_WORDS = 2,
  parameter logic [7:0] PID       = MACPID
) (
  input logic         clk,
  input logic         reset,
  eth_cfg_ram_if.slave bus
);

  localparam int             CW   = $clog2(CFG_WORDS + 2);
  localparam int             BW   = 32 * CFG_WORDS;
  localparam logic [CW-1:0]  FULL = CW'(CFG_WORDS);
  localparam logic [CW-1:0]  SAT  = CW'(CFG_WORDS + 1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_TOKEN, WAIT_APPEND, SEND} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic [CW-1:0]        send_idx, send_idx_nxt;
  logic [BW-1:0]        shadow, shadow_nxt;
  logic [BW-1:0]        bank, bank_nxt;
  logic [15:0]          seqnum, seqnum_nxt;
  logic [15:0]          last_seqnum, last_seqnum_nxt;
  logic [7:0]           reply_type, reply_type_nxt;
  logic                 valid, valid_nxt;
  logic                 update, update_nxt;
  logic                 accept;
  logic                 frame_ok;
  logic                 frame_dup;
  eth_header_t          reply_hdr;
  eth_rx_pipe_data_type rx_q;
  eth_tx_ring_data_type tx_q, tx_nxt;

  assign accept = (bus.rx_pipe_in.stype == rx_start) &&
                  (bus.rx_pipe_in.msg.header.pid == PID) &&
                  (bus.rx_pipe_in.msg.header.ptype == rstPacketType);

  assign reply_hdr = '{pid: PID, ptype: reply_type, seqnum: ldsts_big_endian(seqnum)};

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    send_idx_nxt    = send_idx;
    shadow_nxt      = shadow;
    bank_nxt        = bank;
    seqnum_nxt      = seqnum;
    last_seqnum_nxt = last_seqnum;
    reply_type_nxt  = reply_type;
    valid_nxt       = valid;
    update_nxt      = 1'b0;
    frame_ok        = 1'b0;
    frame_dup       = 1'b0;
    tx_nxt          = bus.tx_ring_in;

    case (state)
      IDLE: begin
        if (accept) begin
          seqnum_nxt = bus.rx_pipe_in.msg.header.seqnum;
          count_nxt  = '0;
          shadow_nxt = '0;
          state_nxt  = RECV;
        end
      end

      RECV: begin
        case (bus.rx_pipe_in.stype)
          rx_start: begin
            // A new start abandons the partial frame; only a matching one restarts capture.
            if (accept) begin
              seqnum_nxt = bus.rx_pipe_in.msg.header.seqnum;
              count_nxt  = '0;
              shadow_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
          rx_data: begin
            if (count < FULL) begin
              shadow_nxt[32*int'(count) +: 32] = bus.rx_pipe_in.msg.data;
            end
            if (count != SAT) begin
              count_nxt = count + 1'b1;
            end
          end
          rx_end: begin
            frame_ok  = (count == FULL) && !bus.rx_pipe_in.msg.data[0];
            frame_dup = frame_ok && valid && (seqnum == last_seqnum);
            if (frame_ok && !frame_dup) begin
              bank_nxt        = shadow;
              valid_nxt       = 1'b1;
              update_nxt      = 1'b1;
              last_seqnum_nxt = seqnum;
            end
            reply_type_nxt = frame_ok ? ackPacketType : nackPacketType;
            state_nxt      = WAIT_TOKEN;
          end
          default: ;
        endcase
      end

      WAIT_TOKEN: begin
        if (bus.tx_ring_in.stype == tx_start_empty) begin
          tx_nxt.stype      = tx_start;
          tx_nxt.msg.header = reply_hdr;
          send_idx_nxt      = '0;
          state_nxt         = SEND;
        end else if (bus.tx_ring_in.stype == tx_start) begin
          state_nxt = WAIT_APPEND;
        end
      end

      WAIT_APPEND: begin
        // Ring already carries a packet; append ours into the first free slot after it.
        if (bus.tx_ring_in.stype == tx_none) begin
          tx_nxt.stype      = slot_start;
          tx_nxt.msg.header = reply_hdr;
          send_idx_nxt      = '0;
          state_nxt         = SEND;
        end
      end

      SEND: begin
        tx_nxt.stype = slot_data;
        if (send_idx < FULL) begin
          tx_nxt.msg.data = bank[32*int'(send_idx) +: 32];
          send_idx_nxt    = send_idx + 1'b1;
        end else begin
          tx_nxt.msg.data = {ldsts_big_endian(seqnum), PID, reply_type};
          state_nxt       = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      send_idx    <= '0;
      shadow      <= '0;
      bank        <= '0;
      seqnum      <= '0;
      last_seqnum <= '0;
      reply_type  <= '0;
      valid       <= 1'b0;
      update      <= 1'b0;
      rx_q.stype  <= rx_none;
      rx_q.msg    <= '0;
      tx_q.stype  <= tx_none;
      tx_q.msg    <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      send_idx    <= send_idx_nxt;
      shadow      <= shadow_nxt;
      bank        <= bank_nxt;
      seqnum      <= seqnum_nxt;
      last_seqnum <= last_seqnum_nxt;
      reply_type  <= reply_type_nxt;
      valid       <= valid_nxt;
      update      <= update_nxt;
      rx_q        <= bus.rx_pipe_in;
      tx_q        <= tx_nxt;
    end
  end

  assign bus.cfg_data    = bank;
  assign bus.cfg_valid   = valid;
  assign bus.cfg_update  = update;
  assign bus.rx_pipe_out = rx_q;
  assign bus.tx_ring_out = tx_q;

endmodule

// File: tb/tb_eth_cfg_ram.sv
// Randomised frame-level bench for eth_cfg_ram with a queue-based scoreboard on the tx ring and bank updates.
module tb_eth_cfg_ram;
  import eth_pkg::*;

  localparam int         N  = 2;
  localparam int         N4 = 4;
  localparam logic [7:0] P  = MACPID;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  eth_cfg_ram_if #(.CFG_WORDS(N))  bus ();
  eth_cfg_ram_if #(.CFG_WORDS(N4)) bus4 ();

  eth_cfg_ram #(.CFG_WORDS(N),  .PID(P)) dut  (.clk(clk), .reset(reset), .bus(bus));
  eth_cfg_ram #(.CFG_WORDS(N4), .PID(P)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int checks = 0;
  int errors = 0;

  eth_tx_ring_data_type tx_exp_q[$];
  logic [32*N-1:0]      cfg_exp_q[$];
  logic [31:0]          m_bank[N];
  logic                 m_valid;
  logic [15:0]          m_last;
  eth_rx_pipe_data_type rx_hist;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic eth_tx_ring_data_type mk_tx(input eth_tx_stype_t s, input logic [31:0] d);
    eth_tx_ring_data_type t;
    t.stype    = s;
    t.msg.data = d;
    return t;
  endfunction

  function automatic eth_tx_stype_t rand_ts();
    case ($urandom_range(0, 4))
      0: return tx_none;
      1: return tx_start;
      2: return tx_start_empty;
      3: return tx_data;
      default: return slot_data;
    endcase
  endfunction

  function automatic logic [32*N-1:0] model_bank();
    logic [32*N-1:0] b;
    for (int i = 0; i < N; i++) b[32*i +: 32] = m_bank[i];
    return b;
  endfunction

  // Output side of the pipe/ring is one register stage behind what was driven.
  always @(posedge clk or posedge reset) begin
    if (reset) rx_hist <= '0;
    else       rx_hist <= bus.rx_pipe_in;
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("rx_pass", bus.rx_pipe_out, rx_hist);
      if (bus.tx_ring_out.stype != tx_none) begin
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", bus.tx_ring_out);
        end else begin
          check("tx_ring", bus.tx_ring_out, tx_exp_q.pop_front());
        end
      end
      if (bus.cfg_update) begin
        if (cfg_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg_update_unexpected actual=%0h required=none", bus.cfg_data);
        end else begin
          check("cfg_data", bus.cfg_data, cfg_exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input eth_rx_stype_t rs, input logic [31:0] rd,
                      input eth_tx_stype_t ts, input logic [31:0] td, input bit pass);
    bus.rx_pipe_in.stype    = rs;
    bus.rx_pipe_in.msg.data = rd;
    bus.tx_ring_in.stype    = ts;
    bus.tx_ring_in.msg.data = td;
    if (pass && ts != tx_none) tx_exp_q.push_back(mk_tx(ts, td));
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] pid, input logic [7:0] ptype, input logic [15:0] seq,
                       input int nw, input bit err, input bit occ, input int gap,
                       input logic [31:0] w0, input logic [31:0] w1, input int rst_at);
    logic [31:0] w[$];
    logic [31:0] wi;
    bit          ok, dup;
    logic [7:0]  rt;
    logic [31:0] hdr;
    eth_rx_stype_t rs;

    step(rx_start, {pid, ptype, seq}, rand_ts(), $urandom, 1'b1);
    for (int i = 0; i < nw; i++) begin
      wi = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
      w.push_back(wi);
      step(rx_data, wi, rand_ts(), $urandom, 1'b1);
    end
    step(rx_end, {31'($urandom), err}, rand_ts(), $urandom, 1'b1);

    if (pid != P || ptype != rstPacketType) begin
      step(rx_none, 32'h0, tx_none, 32'h0, 1'b0);
      step(rx_none, 32'h0, tx_none, 32'h0, 1'b0);
      return;
    end

    ok  = (nw == N) && !err;
    dup = ok && m_valid && (seq == m_last);
    check("cfg_update_timing", bus.cfg_update, ok && !dup);
    if (ok && !dup) begin
      for (int i = 0; i < N; i++) m_bank[i] = w[i];
      m_valid = 1'b1;
      m_last  = seq;
      cfg_exp_q.push_back(model_bank());
    end
    rt  = ok ? ackPacketType : nackPacketType;
    hdr = {P, rt, seq[7:0], seq[15:8]};

    if (occ) begin
      step(rx_none, 32'h0, tx_start, $urandom, 1'b1);
      for (int g = 0; g < gap; g++) step(rx_none, 32'h0, tx_data, $urandom, 1'b1);
      tx_exp_q.push_back(mk_tx(slot_start, hdr));
      step(rx_none, 32'h0, tx_none, $urandom, 1'b0);
    end else begin
      tx_exp_q.push_back(mk_tx(tx_start, hdr));
      step(rx_none, 32'h0, tx_start_empty, $urandom, 1'b0);
    end
    check("hdr_cycle", bus.tx_ring_out.stype, occ ? slot_start : tx_start);

    for (int i = 0; i < N; i++) tx_exp_q.push_back(mk_tx(slot_data, m_bank[i]));
    tx_exp_q.push_back(mk_tx(slot_data, {seq[7:0], seq[15:8], P, rt}));

    for (int i = 0; i <= N; i++) begin
      if (i == rst_at) begin
        bus.rx_pipe_in = '0;
        bus.tx_ring_in = '0;
        reset = 1'b1;
        #1;
        check("rst_tx_none", bus.tx_ring_out.stype, tx_none);
        check("rst_rx_none", bus.rx_pipe_out.stype, rx_none);
        check("rst_cfg_data", bus.cfg_data, 0);
        check("rst_cfg_valid", bus.cfg_valid, 1'b0);
        check("rst_cfg_update", bus.cfg_update, 1'b0);
        tx_exp_q.delete();
        cfg_exp_q.delete();
        for (int k = 0; k < N; k++) m_bank[k] = '0;
        m_valid = 1'b0;
        m_last  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      // rx traffic during a reply must be ignored, including well-formed writes.
      rs = eth_rx_stype_t'($urandom_range(0, 3));
      step(rs, $urandom_range(0, 1) ? {P, rstPacketType, 16'($urandom)} : $urandom,
           tx_data, $urandom, 1'b0);
      check("reply_contiguous", bus.tx_ring_out.stype, slot_data);
    end
    step(rx_none, 32'h0, tx_none, 32'h0, 1'b0);
    check("reply_done", bus.tx_ring_out.stype, tx_none);
    check("cfg_valid", bus.cfg_valid, m_valid);
  endtask

  task automatic step4(input eth_rx_stype_t rs, input logic [31:0] rd, input eth_tx_stype_t ts);
    bus4.rx_pipe_in.stype    = rs;
    bus4.rx_pipe_in.msg.data = rd;
    bus4.tx_ring_in.stype    = ts;
    bus4.tx_ring_in.msg.data = 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]      w4[N4];
    logic [32*N4-1:0] b4;
    eth_tx_ring_data_type exp4;
    int               busy;

    bus.rx_pipe_in  = '0;
    bus.tx_ring_in  = '0;
    bus4.rx_pipe_in = '0;
    bus4.tx_ring_in = '0;
    for (int i = 0; i < N; i++) m_bank[i] = '0;
    m_valid = 1'b0;
    m_last  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cfg_data", bus.cfg_data, 0);
    check("reset_cfg_valid", bus.cfg_valid, 1'b0);
    check("reset_cfg_update", bus.cfg_update, 1'b0);
    check("reset_tx", bus.tx_ring_out.stype, tx_none);
    check("reset_rx", bus.rx_pipe_out.stype, rx_none);
    reset = 1'b0;
    @(posedge clk);
    #1;

    frame(P, rstPacketType, 16'h0102, 2, 1'b0, 1'b0, 0, 32'h00112233, 32'h44550000, -1);
    check("good_bank", bus.cfg_data, {32'h44550000, 32'h00112233});
    frame(P, rstPacketType, 16'h0103, 1, 1'b0, 1'b0, 0, 32'hdeadbeef, 32'h0, -1);
    frame(P, rstPacketType, 16'h0104, 2, 1'b1, 1'b0, 0, 32'hdeadbeef, 32'hcafef00d, -1);
    frame(P, rstPacketType, 16'h0105, 3, 1'b0, 1'b0, 0, 32'hdeadbeef, 32'hcafef00d, -1);
    frame(P, rstPacketType, 16'h0106, 0, 1'b0, 1'b0, 0, 32'h0, 32'h0, -1);
    check("nack_bank_kept", bus.cfg_data, {32'h44550000, 32'h00112233});
    frame(P, rstPacketType, 16'h0102, 2, 1'b0, 1'b0, 0, 32'haaaa0001, 32'hbbbb0002, -1);
    check("dup_bank_kept", bus.cfg_data, {32'h44550000, 32'h00112233});
    frame(P, rstPacketType, 16'h0103, 2, 1'b0, 1'b0, 0, 32'haaaa0001, 32'hbbbb0002, -1);
    check("seq_next_bank", bus.cfg_data, {32'hbbbb0002, 32'haaaa0001});
    frame(P, rstPacketType, 16'h0200, 2, 1'b0, 1'b1, 2, 32'h12345678, 32'h9abcdef0, -1);

    // Restart: a second matching start mid-frame discards the partial capture.
    step(rx_start, {P, rstPacketType, 16'h0777}, tx_none, 32'h0, 1'b0);
    step(rx_data, 32'hffffffff, tx_none, 32'h0, 1'b0);
    frame(P, rstPacketType, 16'h0210, 2, 1'b0, 1'b0, 0, 32'h01010101, 32'h02020202, -1);

    for (int r = 0; r < 25; r++) begin
      frame(($urandom_range(0, 7) == 0) ? P ^ 8'h01 : P,
            ($urandom_range(0, 7) == 0) ? ackPacketType : rstPacketType,
            16'h0100 + 16'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom, $urandom, -1);
    end

    frame(P, rstPacketType, 16'h0300, 2, 1'b0, 1'b0, 0, 32'h11111111, 32'h22222222, 1);
    frame(P ^ 8'h02, rstPacketType, 16'h0301, 2, 1'b0, 1'b0, 0, 32'h33333333, 32'h44444444, -1);
    check("wrong_pid_valid", bus.cfg_valid, 1'b0);
    check("wrong_pid_bank", bus.cfg_data, 0);

    // Four-word instance: full write and a six-cycle reply.
    step4(rx_start, {P, rstPacketType, 16'h0a0b}, tx_none);
    for (int i = 0; i < N4; i++) begin
      w4[i] = $urandom;
      b4[32*i +: 32] = w4[i];
      step4(rx_data, w4[i], tx_none);
    end
    step4(rx_end, 32'h0, tx_none);
    check("n4_update", bus4.cfg_update, 1'b1);
    check("n4_bank", bus4.cfg_data, b4);
    step4(rx_none, 32'h0, tx_start_empty);
    busy = 0;
    for (int k = 0; k < N4 + 3; k++) begin
      if (k == 0)           exp4 = mk_tx(tx_start, {P, ackPacketType, 16'h0b0a});
      else if (k <= N4)     exp4 = mk_tx(slot_data, w4[k-1]);
      else if (k == N4 + 1) exp4 = mk_tx(slot_data, {16'h0b0a, P, ackPacketType});
      else                  exp4 = mk_tx(tx_none, 32'h0);
      check("n4_reply", bus4.tx_ring_out, exp4);
      if (bus4.tx_ring_out.stype != tx_none) busy++;
      step4(rx_none, 32'h0, tx_none);
    end
    check("n4_reply_len", busy, N4 + 2);

    repeat (3) @(posedge clk);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("cfg_queue_drained", cfg_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
